// File: rtl/mul_unit.sv
// mul_unit: iterative shift-and-add 32x32 multiplier for the execute stage.
// Signed operands are reduced to magnitudes up front and the 64-bit result is
// negated once on the last iteration, so the datapath is purely unsigned.
// The product is written back through the register file's single write port
// in one (short) or two (long) registered writeback cycles.

module mul_unit #(
    parameter int DATA_SIZE  = 32,
    parameter int REGS_COUNT = 16,
    parameter int ADDR_SIZE  = $clog2(REGS_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_en,
    input  logic                 long_en,
    input  logic [DATA_SIZE-1:0] op_a,
    input  logic [DATA_SIZE-1:0] op_b,
    input  logic [ADDR_SIZE-1:0] dest_lo,
    input  logic [ADDR_SIZE-1:0] dest_hi,
    output logic                 busy,
    output logic                 done,
    output logic                 write_en,
    output logic [ADDR_SIZE-1:0] write_reg,
    output logic [DATA_SIZE-1:0] write_data
);

    localparam int CNT_W = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(DATA_SIZE - 1);
    localparam logic [ADDR_SIZE-1:0] PC_REG    = ADDR_SIZE'(REGS_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WB_LO,
        WB_HI
    } state_t;

    state_t                 state_q;
    logic [2*DATA_SIZE-1:0] mcand_q;
    logic [DATA_SIZE-1:0]   mplier_q;
    logic [2*DATA_SIZE-1:0] acc_q;
    logic [CNT_W-1:0]       count_q;
    logic                   negate_q;
    logic                   long_q;
    logic [ADDR_SIZE-1:0]   destLo_q;
    logic [ADDR_SIZE-1:0]   destHi_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   writeEn_q;
    logic [ADDR_SIZE-1:0]   writeReg_q;
    logic [DATA_SIZE-1:0]   writeData_q;

    logic [DATA_SIZE-1:0]   magA_d;
    logic [DATA_SIZE-1:0]   magB_d;
    logic                   negate_d;
    logic [2*DATA_SIZE-1:0] accSum_d;
    logic [2*DATA_SIZE-1:0] accFinal_d;

    // Operand magnitudes at capture, one shift-add step, and the sign-corrected final sum
    always_comb begin
        magA_d     = (signed_en && op_a[DATA_SIZE-1]) ? -op_a : op_a;
        magB_d     = (signed_en && op_b[DATA_SIZE-1]) ? -op_b : op_b;
        negate_d   = signed_en & (op_a[DATA_SIZE-1] ^ op_b[DATA_SIZE-1]);
        accSum_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
        accFinal_d = negate_q ? -accSum_d : accSum_d;
    end

    // Control FSM with registered writeback outputs; reset abandons any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            negate_q    <= 1'b0;
            long_q      <= 1'b0;
            destLo_q    <= '0;
            destHi_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            writeEn_q   <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q      <= 1'b0;
                    writeEn_q   <= 1'b0;
                    writeReg_q  <= '0;
                    writeData_q <= '0;
                    if (start) begin
                        mcand_q  <= {{DATA_SIZE{1'b0}}, magA_d};
                        mplier_q <= magB_d;
                        negate_q <= negate_d;
                        long_q   <= long_en;
                        destLo_q <= dest_lo;
                        destHi_q <= dest_hi;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST_ITER) begin
                        acc_q       <= accFinal_d;
                        state_q     <= WB_LO;
                        writeEn_q   <= (destLo_q != PC_REG);
                        writeReg_q  <= destLo_q;
                        writeData_q <= accFinal_d[DATA_SIZE-1:0];
                        done_q      <= ~long_q;
                    end else begin
                        acc_q <= accSum_d;
                    end
                end
                WB_LO: begin
                    if (long_q) begin
                        state_q     <= WB_HI;
                        writeEn_q   <= (destHi_q != PC_REG);
                        writeReg_q  <= destHi_q;
                        writeData_q <= acc_q[2*DATA_SIZE-1:DATA_SIZE];
                        done_q      <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                        writeEn_q   <= 1'b0;
                        writeReg_q  <= '0;
                        writeData_q <= '0;
                    end
                end
                WB_HI: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    writeEn_q   <= 1'b0;
                    writeReg_q  <= '0;
                    writeData_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign write_en   = writeEn_q;
    assign write_reg  = writeReg_q;
    assign write_data = writeData_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: scenario-driven bench for mul_unit.
// Expected register writes come from a 64-bit reference product and are queued
// when an operation is issued; a monitor pops and compares every observed write.

module tb_mul_unit;

    localparam logic [3:0] PC_REG = 4'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_en;
    logic        long_en;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  dest_lo;
    logic [3:0]  dest_hi;
    logic        busy;
    logic        done;
    logic        write_en;
    logic [3:0]  write_reg;
    logic [31:0] write_data;

    typedef struct {
        logic [3:0]  wreg;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   nCompared   = 0;
    int   nMismatched = 0;

    mul_unit #(
        .DATA_SIZE (32),
        .REGS_COUNT(16),
        .ADDR_SIZE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_en (signed_en),
        .long_en   (long_en),
        .op_a      (op_a),
        .op_b      (op_b),
        .dest_lo   (dest_lo),
        .dest_hi   (dest_hi),
        .busy      (busy),
        .done      (done),
        .write_en  (write_en),
        .write_reg (write_reg),
        .write_data(write_data)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Reference full-width product
    function automatic logic [63:0] modelProduct(input logic [31:0] a, input logic [31:0] b,
                                                 input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Scoreboard monitor: every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL unexpected_write: got reg=%0d data=%h, required no write at %0t",
                         write_reg, write_data, $time);
            end else begin
                monExp = expQ.pop_front();
                if ({write_reg, write_data} !== {monExp.wreg, monExp.data}) begin
                    nMismatched++;
                    $display("[TB] FAIL write_value: got reg=%0d data=%h, required reg=%0d data=%h",
                             write_reg, write_data, monExp.wreg, monExp.data);
                end
            end
        end
    end

    // Drive one request; edge E0 is the posedge inside this task
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic l, input logic [3:0] dlo, input logic [3:0] dhi);
        logic [63:0] p;
        p = modelProduct(a, b, s);
        if (dlo != PC_REG) expQ.push_back('{wreg: dlo, data: p[31:0]});
        if (l && dhi != PC_REG) expQ.push_back('{wreg: dhi, data: p[63:32]});
        @(negedge clk);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_en = s;
        long_en   = l;
        dest_lo   = dlo;
        dest_hi   = dhi;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if ({busy, done, write_en, write_reg, write_data} !== 39'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {busy, done, write_en, write_reg, write_data});
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_short();
        issue(32'd7, 32'd6, 1'b0, 1'b0, 4'd3, 4'd0);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            nCompared++;
            if (busy !== (n <= 33)) begin
                nMismatched++;
                $display("[TB] FAIL short_busy E0+%0d: got %b, required %b", n, busy, (n <= 33));
            end
            nCompared++;
            if (done !== (n == 33)) begin
                nMismatched++;
                $display("[TB] FAIL short_done E0+%0d: got %b, required %b", n, done, (n == 33));
            end
            nCompared++;
            if (write_en !== (n == 33)) begin
                nMismatched++;
                $display("[TB] FAIL short_wen E0+%0d: got %b, required %b", n, write_en, (n == 33));
            end
        end
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL short_pending: got %0d outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_unsigned_long();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd1, 4'd2);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            nCompared++;
            if (busy !== (n <= 34)) begin
                nMismatched++;
                $display("[TB] FAIL long_busy E0+%0d: got %b, required %b", n, busy, (n <= 34));
            end
            nCompared++;
            if (done !== (n == 34)) begin
                nMismatched++;
                $display("[TB] FAIL long_done E0+%0d: got %b, required %b", n, done, (n == 34));
            end
            nCompared++;
            if (write_en !== (n == 33 || n == 34)) begin
                nMismatched++;
                $display("[TB] FAIL long_wen E0+%0d: got %b, required %b", n, write_en,
                         (n == 33 || n == 34));
            end
        end
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL long_pending: got %0d outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_signed_long();
        logic [31:0] aList[2];
        logic [31:0] bList[2];
        aList = '{32'hFFFF_FFFD, 32'h8000_0000};
        bList = '{32'h0000_0005, 32'h8000_0000};
        for (int k = 0; k < 2; k++) begin
            issue(aList[k], bList[k], 1'b1, 1'b1, 4'd5 + 4'(2 * k), 4'd6 + 4'(2 * k));
            for (int n = 1; n <= 35; n++) begin
                @(negedge clk);
                nCompared++;
                if (done !== (n == 34)) begin
                    nMismatched++;
                    $display("[TB] FAIL signed_done run%0d E0+%0d: got %b, required %b",
                             k, n, done, (n == 34));
                end
            end
            nCompared++;
            if (expQ.size() != 0) begin
                nMismatched++;
                $display("[TB] FAIL signed_pending run%0d: got %0d outstanding, required 0",
                         k, expQ.size());
                expQ.delete();
            end
        end
    endtask

    task automatic test_busy_reject();
        issue(32'd1000, 32'd3, 1'b0, 1'b0, 4'd9, 4'd0);
        for (int n = 1; n <= 42; n++) begin
            @(negedge clk);
            nCompared++;
            if (busy !== (n <= 33)) begin
                nMismatched++;
                $display("[TB] FAIL reject_busy E0+%0d: got %b, required %b", n, busy, (n <= 33));
            end
            if (n == 10 || n == 33) begin
                start     = 1'b1;
                op_a      = 32'd55;
                op_b      = 32'd77;
                signed_en = 1'b1;
                long_en   = 1'b1;
                dest_lo   = 4'd10;
                dest_hi   = 4'd11;
            end
            if (n == 11 || n == 34) start = 1'b0;
        end
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL reject_pending: got %0d outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset_mid();
        issue(32'd9, 32'd9, 1'b0, 1'b1, 4'd1, 4'd2);
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 10) rst = 1'b1;
            if (n == 11) begin
                nCompared++;
                if ({busy, done, write_en, write_reg, write_data} !== 39'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL midreset_outputs: got %h, required 0",
                             {busy, done, write_en, write_reg, write_data});
                end
                rst = 1'b0;
                expQ.delete();
            end
            if (n > 11) begin
                nCompared++;
                if ({busy, write_en} !== 2'b00) begin
                    nMismatched++;
                    $display("[TB] FAIL midreset_idle E0+%0d: got busy/wen=%b, required 00",
                             n, {busy, write_en});
                end
            end
        end
        issue(32'd2, 32'd2, 1'b0, 1'b0, 4'd3, 4'd0);
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            nCompared++;
            if (done !== (n == 33)) begin
                nMismatched++;
                $display("[TB] FAIL fresh_done E0+%0d: got %b, required %b", n, done, (n == 33));
            end
        end
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL fresh_pending: got %0d outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset_wblo();
        issue(32'd3, 32'd4, 1'b0, 1'b1, 4'd5, 4'd6);
        for (int n = 1; n <= 37; n++) begin
            @(negedge clk);
            if (n == 33) begin
                nCompared++;
                if (write_en !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL wblo_wen: got %b, required 1", write_en);
                end
                rst = 1'b1;
            end
            if (n >= 34) begin
                nCompared++;
                if ({busy, done, write_en, write_reg, write_data} !== 39'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL wblo_reset E0+%0d: got %h, required 0", n,
                             {busy, done, write_en, write_reg, write_data});
                end
                rst = 1'b0;
                expQ.delete();
            end
        end
    endtask

    task automatic test_pc_dest();
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, PC_REG, 4'd4);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            nCompared++;
            if (busy !== (n <= 34)) begin
                nMismatched++;
                $display("[TB] FAIL pc_busy E0+%0d: got %b, required %b", n, busy, (n <= 34));
            end
            nCompared++;
            if ({write_en, done} !== {(n == 34), (n == 34)}) begin
                nMismatched++;
                $display("[TB] FAIL pc_wen_done E0+%0d: got %b%b, required %b%b",
                         n, write_en, done, (n == 34), (n == 34));
            end
        end
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL pc_pending: got %0d outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Scenario sequence
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        signed_en = 1'b0;
        long_en   = 1'b0;
        op_a      = '0;
        op_b      = '0;
        dest_lo   = '0;
        dest_hi   = '0;
        test_reset();
        test_unsigned_short();
        test_unsigned_long();
        test_signed_long();
        test_busy_reject();
        test_reset_mid();
        test_reset_wblo();
        test_pc_dest();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
